// File: rtl/spi_pkg.sv
// Shared SPI definitions: state encoding, default frame width, mode constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

    // Default bits per frame
    localparam int SPI_DATA_WIDTH = 16;

    // One-hot frame states, same encoding style as the SPIMaster
    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_SHIFT = 3'b010;
    localparam logic [2:0] ST_DONE  = 3'b100;

    // Bus mode as {ckp, cph}
    typedef struct packed {
        logic ckp;
        logic cph;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{ckp: 1'b0, cph: 1'b0};
    localparam spi_mode_t MODE1 = '{ckp: 1'b0, cph: 1'b1};
    localparam spi_mode_t MODE2 = '{ckp: 1'b1, cph: 1'b0};
    localparam spi_mode_t MODE3 = '{ckp: 1'b1, cph: 1'b1};

    // Sample edge is the leading edge for CPH=0, the trailing edge for CPH=1.
    // Calling it with lead/trail swapped yields the shift edge.
    function automatic logic pick_edge(input logic cph, input logic lead, input logic trail);
        return cph ? trail : lead;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with one registered previous value for edge detection.
// Latency: level follows the pin after STAGES clk; rise/fall pulse in the cycle after that.
// Backpressure: none, free-running.
//
// Ports: clk, rst (sync, active high), din_i (async pin),
//        level_o (synchronized level), rise_o / fall_o (one-clk edge pulses).
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave: LSB-first DATA_WIDTH-bit frames in on MOSI, tx_data out on MISO.
// Latency: bus edges act SYNC_STAGES+1 clk after the pin change; rx_valid one clk after the last sample.
// Backpressure: none; rx_data is overwritten by each complete frame, consumer must keep up.
//
// Ports: clk, rst (sync, active high), CKP/CPH (mode), SCK/CS/MOSI (async bus inputs),
//        MISO (serial out), tx_data (captured at CS assertion), rx_data/rx_valid (received word),
//        busy (frame in progress), frame_err (CS released mid-frame).
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CKP,
    input  logic                  CPH,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // ---------------------------------------------------------------
    // Bus synchronizers
    // ---------------------------------------------------------------
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .din_i   (SCK),
        .level_o (sck_lvl_unused),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // CS presets high so reset never looks like a chip-select assertion
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .din_i   (CS),
        .level_o (cs_lvl_unused),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .din_i   (MOSI),
        .level_o (mosi_s),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    // ---------------------------------------------------------------
    // Edge qualification
    // ---------------------------------------------------------------
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    // Leading edge leaves the idle (CKP) level, trailing edge returns to it
    assign lead_edge   = CKP ? sck_fall : sck_rise;
    assign trail_edge  = CKP ? sck_rise : sck_fall;
    assign sample_edge = pick_edge(CPH, lead_edge, trail_edge);
    assign shift_edge  = pick_edge(CPH, trail_edge, lead_edge);

    // ---------------------------------------------------------------
    // Frame state
    // ---------------------------------------------------------------
    logic [2:0]            state_q,    state_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
    logic                  miso_q,     miso_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [IDX_W-1:0]      bit_idx;

    // bit_cnt never exceeds DATA_WIDTH-1 while it is used as an index
    assign bit_idx = bit_cnt_q[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = ST_SHIFT;
                    // CPH=0: first bit must be on the wire before the first sample edge
                    if (!CPH) begin
                        miso_d = tx_data[0];
                    end
                end
            end

            ST_SHIFT: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (sample_edge) begin
                    rx_shift_d[bit_idx] = mosi_s;
                    bit_cnt_d           = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else if (shift_edge) begin
                    // bit_cnt counts samples already taken, so it indexes the next
                    // bit to present in both phases: CPH=1 before its sample, CPH=0
                    // one past the bit just sampled.
                    miso_d = tx_shift_q[bit_idx];
                end
            end

            ST_DONE: begin
                // SCK edges ignored; MISO holds its last bit until CS releases
                if (cs_rise) begin
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                miso_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign MISO      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives frames in all four modes.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int DW   = 16;
    localparam int HALF = 6;   // SCK half period in clk cycles

    logic          clk = 1'b0;
    logic          rst;
    logic          CKP, CPH, SCK, CS, MOSI;
    logic          MISO;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          rx_valid, busy, frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_ferr = 0;
    logic [DW-1:0] exp_rx;   // reference: last fully received word

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .CKP       (CKP),
        .CPH       (CPH),
        .SCK       (SCK),
        .CS        (CS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid)  n_valid++;
        if (frame_err) n_ferr++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One master transaction. nbits < DW aborts by releasing CS early, nbits > DW
    // adds extra SCK edges, do_rst pulses reset instead of releasing CS normally.
    task automatic run_frame(input spi_mode_t mode, input logic [DW-1:0] mw,
                             input logic [DW-1:0] tw, input int nbits, input bit do_rst);
        logic [DW-1:0] got;
        int  v0, f0, j;
        bit  full;
        got = '0;
        if (mode.ckp !== CKP || mode.cph !== CPH) begin
            @(negedge clk);
            CKP = mode.ckp; CPH = mode.cph; SCK = mode.ckp;
            repeat (4) @(negedge clk);
        end
        v0 = n_valid;
        f0 = n_ferr;
        @(negedge clk);
        tx_data = tw;
        MOSI    = mw[0];
        CS      = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            j = i % DW;
            if (CPH) MOSI = mw[j[3:0]];
            else if (i < DW) got[j[3:0]] = MISO;
            SCK = ~CKP;
            repeat (HALF) @(negedge clk);
            if (CPH && i < DW) got[j[3:0]] = MISO;
            SCK = CKP;
            if (!CPH) begin
                j = (i + 1) % DW;
                MOSI = mw[j[3:0]];
            end
            repeat (HALF) @(negedge clk);
        end
        check_val("busy_mid", 32'(busy), (nbits >= DW) ? 32'd0 : 32'd1);
        if (do_rst) begin
            rst = 1'b1;
            CS  = 1'b1;
            @(negedge clk);
            check_val("rst_miso",      32'(MISO),      32'd0);
            check_val("rst_rx_data",   32'(rx_data),   32'd0);
            check_val("rst_rx_valid",  32'(rx_valid),  32'd0);
            check_val("rst_busy",      32'(busy),      32'd0);
            check_val("rst_frame_err", 32'(frame_err), 32'd0);
            rst = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            CS = 1'b1;
            repeat (4) @(negedge clk);
        end
        full = (nbits >= DW) && !do_rst;
        if (full) exp_rx = mw;
        if (do_rst) exp_rx = '0;
        check_val("valid_pulses", 32'(n_valid - v0), full ? 32'd1 : 32'd0);
        check_val("ferr_pulses",  32'(n_ferr - f0),  (!full && !do_rst) ? 32'd1 : 32'd0);
        check_val("rx_data",      32'(rx_data), 32'(exp_rx));
        if (full) check_val("master_rx", 32'(got), 32'(tw));
        check_val("miso_idle",    32'(MISO), 32'd0);
        check_val("busy_idle",    32'(busy), 32'd0);
        check_val("sck_idle",     32'(SCK),  32'(CKP));
    endtask

    initial begin
        spi_mode_t m;
        int nb;
        rst = 1'b1; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
        tx_data = '0;
        exp_rx  = '0;
        repeat (3) @(negedge clk);
        check_val("reset_miso",      32'(MISO),      32'd0);
        check_val("reset_rx_data",   32'(rx_data),   32'd0);
        check_val("reset_rx_valid",  32'(rx_valid),  32'd0);
        check_val("reset_busy",      32'(busy),      32'd0);
        check_val("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // All four modes with the same words
        run_frame(MODE0, 16'h0407, 16'hA5C3, DW, 1'b0);
        run_frame(MODE1, 16'h0407, 16'hA5C3, DW, 1'b0);
        run_frame(MODE2, 16'h0407, 16'hA5C3, DW, 1'b0);
        run_frame(MODE3, 16'h0407, 16'hA5C3, DW, 1'b0);

        // Abort after 5 samples, then a clean frame
        run_frame(MODE0, 16'hBEEF, 16'h5555, 5, 1'b0);
        run_frame(MODE0, 16'h1234, 16'h0F0F, DW, 1'b0);

        // Reset after 8 bits, then an all-ones frame
        run_frame(MODE1, 16'hCAFE, 16'h3333, 8, 1'b1);
        run_frame(MODE1, 16'hFFFF, 16'h8001, DW, 1'b0);

        // Back-to-back frames with a 4-clk CS-high gap and new tx_data
        run_frame(MODE0, 16'h0001, 16'hA5C3, DW, 1'b0);
        run_frame(MODE0, 16'h8000, 16'h00FF, DW, 1'b0);

        // Extra SCK edges after the last bit
        run_frame(MODE2, 16'h6789, 16'h1357, DW + 4, 1'b0);
        run_frame(MODE3, 16'h4321, 16'h2468, DW + 3, 1'b0);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            m  = spi_mode_t'(2'($urandom_range(0, 3)));
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW - 1)) : DW;
            run_frame(m, 16'($urandom), 16'($urandom), nb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
